// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types, used by the register file,
// control unit and ALU.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_SP   = 5'd29;
    localparam reg_addr_t REG_RA   = 5'd31;

endpackage

// File: rtl/porta_leitura.sv
// Combinational register-file read port: $0 forced to zero, optional
// write-first forwarding when REGFILE_BYPASS_EN is defined.
module porta_leitura #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] sel_s;

`ifndef REGFILE_BYPASS_EN
    // Write port is only observed by the forwarding path.
    logic unused_wr_s;
    assign unused_wr_s = ^{wr_en, wr_addr, wr_data};
`endif

    // Select stored or forwarded word, then force $0 to zero.
    always_comb begin
        sel_s   = regs[rd_addr];
        rd_data = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr)) begin
            sel_s = wr_data;
        end else begin
            sel_s = regs[rd_addr];
        end
`endif
        if (rd_addr == {ADDR_W{1'b0}}) begin
            rd_data = {DATA_W{1'b0}};
        end else begin
            rd_data = sel_s;
        end
    end

endmodule

// File: rtl/banco_registradores.sv
// 32 x 32-bit MIPS register file: two async read ports, one sync write port,
// per-register dirty scoreboard. Optional forwarding: REGFILE_BYPASS_EN.
module banco_registradores #(
    parameter int                 DATA_W   = 32,
    parameter int                 ADDR_W   = 5,
    parameter logic [DATA_W-1:0]  RESET_SP = 32'h7FFF_EFFC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    rs_addr,
    input  logic [ADDR_W-1:0]    rt_addr,
    output logic [DATA_W-1:0]    rs_data,
    output logic [DATA_W-1:0]    rt_data,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    output logic [2**ADDR_W-1:0] dirty
);

    import mips_pkg::*;

    localparam int NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs_r [NREGS];
    logic [NREGS-1:0]  dirty_r;
    logic              wr_ok_s;

    // Writes aimed at $0 are dropped so its storage and dirty bit stay clear.
    assign wr_ok_s = wr_en && (wr_addr != {ADDR_W{1'b0}});

    // Register storage and dirty scoreboard; $29 comes out of reset as sp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= (i == int'(REG_SP)) ? RESET_SP : {DATA_W{1'b0}};
            end
            dirty_r <= {NREGS{1'b0}};
        end else if (wr_ok_s) begin
            regs_r[wr_addr]  <= wr_data;
            dirty_r[wr_addr] <= 1'b1;
        end
    end

    assign dirty = dirty_r;

    porta_leitura #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_porta_rs (
        .regs    (regs_r),
        .rd_addr (rs_addr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rs_data)
    );

    porta_leitura #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_porta_rt (
        .regs    (regs_r),
        .rd_addr (rt_addr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rt_data)
    );

endmodule

// File: tb/tb_banco_registradores.sv
// Self-checking bench for banco_registradores: directed cases with literal
// expectations plus a randomized run against an array reference model.
module tb_banco_registradores;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs_addr = 5'd0;
    logic [4:0]  rt_addr = 5'd0;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = 5'd0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] dirty;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [31:0] model [32];
    logic [31:0] model_dirty;

    banco_registradores dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .dirty   (dirty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = (i == 29) ? 32'h7FFF_EFFC : 32'h0;
        model_dirty = 32'h0;
    endtask

    // Expected read value for an address given the current write-port inputs.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (rst_n && wr_en && (wr_addr == a)) return wr_data;
`endif
        return model[a];
    endfunction

    initial model_reset();

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (rst_n && wr_en && (wr_addr != 5'd0)) begin
            model[wr_addr] = wr_data;
            model_dirty[wr_addr] = 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_rs", rs_data, exp_read(rs_addr));
            check("cyc_rt", rt_data, exp_read(rt_addr));
            check("cyc_dirty", dirty, model_dirty);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [31:0] exp_rd;

        // Reset sweep with literal expectations.
        #3;
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a);
            rt_addr = 5'(31 - a);
            #1;
            check("rst_rs", rs_data, (a == 29) ? 32'h7FFF_EFFC : 32'h0);
        end
        check("rst_dirty", dirty, 32'h0);

        step();
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Write $8, read it back on both ports next cycle.
        wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hDEAD_BEEF;
        step();
        wr_en = 1'b0; rs_addr = 5'd8; rt_addr = 5'd8;
        #1;
        check("wr8_rs", rs_data, 32'hDEAD_BEEF);
        check("wr8_rt", rt_data, 32'hDEAD_BEEF);
        check("wr8_dirty", 32'(dirty[8]), 32'h1);

        // $0 protection.
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; rs_addr = 5'd0;
        step();
        wr_en = 1'b0;
        #1;
        check("r0_rs", rs_data, 32'h0);
        check("r0_dirty", 32'(dirty[0]), 32'h0);

        // Read-during-write on $5.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1;
        step();
        wr_data = 32'h2; rs_addr = 5'd5;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_rd = 32'h2;
`else
        exp_rd = 32'h1;
`endif
        check("rdw_before", rs_data, exp_rd);
        step();
        wr_en = 1'b0;
        #1;
        check("rdw_after", rs_data, 32'h2);

        // Async reset between edges clears $31 without a clock edge.
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h0040_0008; rs_addr = 5'd31;
        step();
        wr_en = 1'b0;
        #1;
        check("ra_written", rs_data, 32'h0040_0008);
        rst_n = 1'b0;
        #1;
        check("ra_async_rst", rs_data, 32'h0);
        check("ra_dirty", 32'(dirty[31]), 32'h0);
        rs_addr = 5'd29;
        #1;
        check("sp_async_rst", rs_data, 32'h7FFF_EFFC);
        step();
        rst_n = 1'b1;

        // Randomized regression.
        for (int n = 0; n < 10000; n++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            wr_data = $urandom;
            rs_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            rt_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            step();
        end

        wr_en = 1'b0;
        step();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
